// File: rtl/bus_bridge_m68k.sv
// 68k-style asynchronous bus bridge: synchronises CPU bus pins, issues one-cycle
// read/write strobes to the core and answers with DTACK on ack or on timeout.
module bus_bridge_m68k #(
  parameter int BUS_WIDTH   = 8,
  parameter int REG_BITS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 bus_cs_n_i,
  input  logic                 bus_rd_nwr_i,
  input  logic [REG_BITS:0]    bus_addr_i,
  input  logic [1:0]           bus_be_n_i,
  input  logic [BUS_WIDTH-1:0] bus_data_i,
  output logic [BUS_WIDTH-1:0] bus_data_o,
  output logic                 bus_out_ena_o,
  output logic                 bus_dtack_n_o,
  output logic                 write_strobe_o,
  output logic                 read_strobe_o,
  output logic [REG_BITS-1:0]  reg_num_o,
  output logic [1:0]           byte_en_o,
  output logic [15:0]          data_o,
  input  logic [15:0]          data_i,
  input  logic                 rd_ack_i,
  input  logic                 wr_ack_i,
  output logic                 timeout_o
);

  localparam int CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, ACKED} state_t;

  state_t                          state, state_nx;
  logic [SYNC_STAGES-1:0]          cs_sync, rnw_sync;
  logic [SYNC_STAGES-1:0][1:0]     be_sync;
  logic                            cs_s, rnw_s;
  logic [1:0]                      be_s;
  logic [1:0]                      lane_en;
  logic [15:0]                     wdata;
  logic [15:0]                     rd_latch;
  logic                            rnw_q, byte_sel;
  logic [CNT_W-1:0]                cnt;
  logic                            ack_hit, tmo_hit, go_wait;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign rnw_s = rnw_sync[SYNC_STAGES-1];
  assign be_s  = be_sync[SYNC_STAGES-1];

  // Control pins cross into clk here; chains idle high so a reset looks like "not selected".
  always_ff @(posedge clk) begin
    if (reset_i) begin
      cs_sync  <= '1;
      rnw_sync <= '1;
      be_sync  <= '1;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus_cs_n_i};
      rnw_sync <= {rnw_sync[SYNC_STAGES-2:0], bus_rd_nwr_i};
      be_sync  <= {be_sync[SYNC_STAGES-2:0], bus_be_n_i};
    end
  end

  if (BUS_WIDTH == 8) begin : g_w8
    wire unused_be = &{1'b0, be_s};
    assign lane_en    = bus_addr_i[0] ? 2'b01 : 2'b10;
    assign wdata      = {bus_data_i, bus_data_i};
    assign bus_data_o = byte_sel ? rd_latch[7:0] : rd_latch[15:8];
  end else begin : g_w16
    wire unused_sel = &{1'b0, byte_sel};
    assign lane_en    = ~be_s;
    assign wdata      = bus_data_i;
    assign bus_data_o = rd_latch;
  end

  always_comb begin
    state_nx = state;
    ack_hit  = rnw_q ? rd_ack_i : wr_ack_i;
    tmo_hit  = (ACK_TIMEOUT != 0) && (cnt == CNT_W'(ACK_TIMEOUT));
    case (state)
      IDLE:     if (!cs_s) state_nx = SETUP;
      SETUP:    if (cs_s) state_nx = IDLE;
                else if (lane_en == 2'b00) state_nx = ACKED;
                else state_nx = WAIT_ACK;
      WAIT_ACK: if (cs_s) state_nx = IDLE;
                else if (ack_hit || tmo_hit) state_nx = ACKED;
      ACKED:    if (cs_s) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign go_wait = (state == SETUP) && (state_nx == WAIT_ACK);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state          <= IDLE;
      bus_out_ena_o  <= 1'b0;
      bus_dtack_n_o  <= 1'b1;
      write_strobe_o <= 1'b0;
      read_strobe_o  <= 1'b0;
      timeout_o      <= 1'b0;
      reg_num_o      <= '0;
      byte_en_o      <= '0;
      data_o         <= '0;
      rd_latch       <= '0;
      rnw_q          <= 1'b0;
      byte_sel       <= 1'b0;
      cnt            <= '0;
    end else begin
      state          <= state_nx;
      bus_out_ena_o  <= !cs_s && rnw_s;
      bus_dtack_n_o  <= (state_nx != ACKED);
      write_strobe_o <= go_wait && !rnw_s;
      read_strobe_o  <= go_wait && rnw_s;
      // Ack beats a simultaneous timeout; an aborted cycle reports neither.
      timeout_o      <= (state == WAIT_ACK) && !cs_s && !ack_hit && tmo_hit;
      if (state == SETUP) begin
        reg_num_o <= bus_addr_i[REG_BITS:1];
        byte_en_o <= lane_en;
        data_o    <= wdata;
        rnw_q     <= rnw_s;
        byte_sel  <= bus_addr_i[0];
      end
      if (state == WAIT_ACK) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (!cs_s) begin
          if (ack_hit) begin
            if (rnw_q) rd_latch <= data_i;
          end else if (tmo_hit) begin
            rd_latch <= 16'hFFFF;
          end
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_bridge_m68k.sv
// Bench for bus_bridge_m68k: an 8-bit and a 16-bit bridge driven by the same bus,
// each checked per access against expectations derived from the bus protocol.
module tb_bus_bridge_m68k;

  localparam int SYNC = 2;
  localparam int TMO  = 15;
  localparam int LAT  = SYNC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n, rnw, rd_ack, wr_ack;
  logic [4:0]  addr;
  logic [1:0]  be_n;
  logic [15:0] bdi, core_di;

  wire [1:0]       wstb, rstb, dtn, oena, tmo;
  wire [1:0][3:0]  rnum;
  wire [1:0][1:0]  ben;
  wire [1:0][15:0] dcore, bdo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign bdo[0][15:8] = 8'h00;

  bus_bridge_m68k #(.BUS_WIDTH(8), .REG_BITS(4), .SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO)) dut8 (
    .clk(clk), .reset_i(rst), .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rnw), .bus_addr_i(addr),
    .bus_be_n_i(be_n), .bus_data_i(bdi[7:0]), .bus_data_o(bdo[0][7:0]), .bus_out_ena_o(oena[0]),
    .bus_dtack_n_o(dtn[0]), .write_strobe_o(wstb[0]), .read_strobe_o(rstb[0]),
    .reg_num_o(rnum[0]), .byte_en_o(ben[0]), .data_o(dcore[0]), .data_i(core_di),
    .rd_ack_i(rd_ack), .wr_ack_i(wr_ack), .timeout_o(tmo[0]));

  bus_bridge_m68k #(.BUS_WIDTH(16), .REG_BITS(4), .SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO)) dut16 (
    .clk(clk), .reset_i(rst), .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rnw), .bus_addr_i(addr),
    .bus_be_n_i(be_n), .bus_data_i(bdi), .bus_data_o(bdo[1]), .bus_out_ena_o(oena[1]),
    .bus_dtack_n_o(dtn[1]), .write_strobe_o(wstb[1]), .read_strobe_o(rstb[1]),
    .reg_num_o(rnum[1]), .byte_en_o(ben[1]), .data_o(dcore[1]), .data_i(core_di),
    .rd_ack_i(rd_ack), .wr_ack_i(wr_ack), .timeout_o(tmo[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete access; d = cycles from strobe to ack (negative: core never acks).
  task automatic access(input bit r, input logic [3:0] rg, input bit a0, input logic [1:0] bn,
                        input logic [15:0] wd, input logic [15:0] cd, input int d,
                        input int hold, input bit stray);
    int   nstb[2], stb_cyc[2], dt_cyc[2], ntmo[2], drop[2];
    bit   was_rd[2];
    logic [3:0]  s_rn[2];
    logic [1:0]  s_be[2];
    logic [15:0] s_do[2];
    logic [15:0] last_bdo[2];
    logic        last_oe[2];
    bit   exp_stb, tmo_exp;
    int   exp_dt, nc, rel;
    logic [15:0] latch, exp_bdo, exp_do;
    logic [1:0]  exp_be;
    for (int k = 0; k < 2; k++) begin
      nstb[k] = 0; stb_cyc[k] = 0; dt_cyc[k] = 0; ntmo[k] = 0; drop[k] = 0; was_rd[k] = 0;
    end
    tmo_exp = (d < 0) || (d > TMO);
    latch   = tmo_exp ? 16'hFFFF : cd;
    nc      = LAT + TMO + 6 + hold;
    @(negedge clk);
    rnw = r; addr = {rg, a0}; be_n = bn; bdi = wd; core_di = cd; cs_n = 1'b0;
    for (int cyc = 1; cyc <= nc; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (wstb[k] || rstb[k]) begin
          nstb[k]++;
          if (stb_cyc[k] == 0) begin
            stb_cyc[k] = cyc; was_rd[k] = rstb[k];
            s_rn[k] = rnum[k]; s_be[k] = ben[k]; s_do[k] = dcore[k];
          end
        end
        if (!dtn[k] && dt_cyc[k] == 0) dt_cyc[k] = cyc;
        if (dtn[k] && dt_cyc[k] != 0) drop[k] = 1;
        if (tmo[k]) ntmo[k]++;
        last_bdo[k] = bdo[k]; last_oe[k] = oena[k];
      end
      rd_ack = 1'b0; wr_ack = 1'b0;
      if (stb_cyc[0] != 0) begin
        if (d >= 0 && cyc == stb_cyc[0] + d) begin
          if (r) rd_ack = 1'b1; else wr_ack = 1'b1;
        end
        if (stray && cyc == stb_cyc[0]) begin
          if (r) wr_ack = 1'b1; else rd_ack = 1'b1;
        end
        if (stray && cyc == stb_cyc[0] + 18) begin
          if (r) rd_ack = 1'b1; else wr_ack = 1'b1;
        end
      end
    end
    rd_ack = 1'b0; wr_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_stb = !(k == 1 && bn == 2'b11);
      exp_dt  = exp_stb ? LAT + (tmo_exp ? TMO + 1 : d + 1) : LAT;
      exp_be  = (k == 0) ? (a0 ? 2'b01 : 2'b10) : ~bn;
      exp_do  = (k == 0) ? {wd[7:0], wd[7:0]} : wd;
      exp_bdo = (k == 0) ? (a0 ? {8'h00, latch[7:0]} : {8'h00, latch[15:8]}) : latch;
      chk($sformatf("strobes[%0d]", k), nstb[k], exp_stb ? 1 : 0);
      chk($sformatf("dtack_cyc[%0d]", k), dt_cyc[k], exp_dt);
      chk($sformatf("dtack_held[%0d]", k), drop[k], 0);
      chk($sformatf("timeout_cnt[%0d]", k), ntmo[k], (exp_stb && tmo_exp) ? 1 : 0);
      chk($sformatf("out_ena[%0d]", k), last_oe[k], r);
      if (exp_stb) begin
        chk($sformatf("stb_lat[%0d]", k), stb_cyc[k], LAT);
        chk($sformatf("stb_type[%0d]", k), was_rd[k], r);
        chk($sformatf("reg_num[%0d]", k), s_rn[k], rg);
        chk($sformatf("byte_en[%0d]", k), s_be[k], exp_be);
        if (!r) chk($sformatf("wdata[%0d]", k), s_do[k], exp_do);
        if (r)  chk($sformatf("rdata[%0d]", k), last_bdo[k], exp_bdo);
      end
    end
    cs_n = 1'b1;
    rel = 0;
    for (int cyc = 1; cyc <= 8 && rel == 0; cyc++) begin
      @(negedge clk);
      if (dtn == 2'b11) rel = cyc;
    end
    chk("dtack_release", (rel > 0) ? 1 : 0, 1);
    chk("release_lat", rel, SYNC + 1);
    @(negedge clk);
    chk("out_ena_idle", oena, 2'b00);
    if (stray) begin rd_ack = 1'b1; wr_ack = 1'b1; end
    @(negedge clk);
    rd_ack = 1'b0; wr_ack = 1'b0;
    @(negedge clk);
  endtask

  // CS withdrawn after the strobe; the ack that follows must not produce DTACK.
  task automatic abort_wait(input bit r);
    int s, nstb, ndt;
    s = 0; nstb = 0; ndt = 0;
    @(negedge clk);
    rnw = r; addr = 5'h04; be_n = 2'b00; core_di = 16'h1111; cs_n = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (wstb[0] || rstb[0]) begin nstb++; if (s == 0) s = cyc; end
      if (dtn != 2'b11) ndt++;
      rd_ack = 1'b0; wr_ack = 1'b0;
      if (s != 0 && cyc == s) cs_n = 1'b1;
      if (s != 0 && cyc == s + 3) begin if (r) rd_ack = 1'b1; else wr_ack = 1'b1; end
    end
    rd_ack = 1'b0; wr_ack = 1'b0; cs_n = 1'b1;
    chk("abort_strobe", nstb, 1);
    chk("abort_dtack", ndt, 0);
    @(negedge clk);
  endtask

  // Single-cycle CS glitch: enters SETUP and backs out without a strobe.
  task automatic setup_abort();
    int nstb, ndt;
    nstb = 0; ndt = 0;
    @(negedge clk);
    rnw = 1'b0; addr = 5'h06; be_n = 2'b00; cs_n = 1'b0;
    @(negedge clk);
    cs_n = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (wstb != 2'b00 || rstb != 2'b00) nstb++;
      if (dtn != 2'b11) ndt++;
    end
    chk("setup_abort_strobe", nstb, 0);
    chk("setup_abort_dtack", ndt, 0);
  endtask

  task automatic reset_in_acked();
    int s, got;
    s = 0; got = 0;
    @(negedge clk);
    rnw = 1'b1; addr = 5'h02; be_n = 2'b00; core_di = 16'h0F0F; cs_n = 1'b0;
    for (int cyc = 1; cyc <= 20 && got == 0; cyc++) begin
      @(negedge clk);
      rd_ack = 1'b0;
      if (rstb[0] && s == 0) begin s = cyc; rd_ack = 1'b1; end
      if (dtn == 2'b00) got = 1;
    end
    rd_ack = 1'b0;
    chk("rst_reach_acked", got, 1);
    rst = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    chk("rst_dtack", dtn, 2'b11);
    chk("rst_out_ena", oena, 2'b00);
    chk("rst_strobe", {wstb, rstb}, 4'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit r, a0, st;
    logic [1:0] bn;
    int d, pick;
    rst = 1'b1; cs_n = 1'b1; rnw = 1'b1; addr = '0; be_n = 2'b11;
    bdi = '0; core_di = '0; rd_ack = 1'b0; wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_dtack[%0d]", k), dtn[k], 1'b1);
      chk($sformatf("reset_oena[%0d]", k), oena[k], 1'b0);
      chk($sformatf("reset_stb[%0d]", k), {wstb[k], rstb[k], tmo[k]}, 3'b000);
      chk($sformatf("reset_regs[%0d]", k), {rnum[k], ben[k], dcore[k]}, 22'h0);
      chk($sformatf("reset_bdo[%0d]", k), bdo[k], 16'h0000);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    access(1'b0, 4'd3, 1'b1, 2'b00, 16'h005A, 16'h0000, 1, 2, 1'b0);
    access(1'b1, 4'd7, 1'b0, 2'b00, 16'h0000, 16'hBEEF, 2, 3, 1'b0);
    access(1'b1, 4'd5, 1'b1, 2'b00, 16'h1234, 16'h5678, -1, 2, 1'b0);
    abort_wait(1'b1);
    access(1'b0, 4'd9, 1'b0, 2'b10, 16'hA5C3, 16'h0000, 0, 100, 1'b1);
    access(1'b1, 4'd4, 1'b0, 2'b11, 16'h0000, 16'h4321, 1, 2, 1'b0);
    access(1'b1, 4'd6, 1'b1, 2'b01, 16'h0000, 16'hCAFE, 15, 2, 1'b1);
    setup_abort();
    reset_in_acked();
    access(1'b1, 4'd1, 1'b1, 2'b00, 16'h0000, 16'h9A7B, 3, 1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r  = 1'($urandom_range(0, 1));
      a0 = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      bn = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      pick = $urandom_range(0, 7);
      case (pick)
        0: d = 0;
        1: d = 1;
        2: d = 2;
        3: d = $urandom_range(3, 14);
        4: d = 15;
        5: d = 16;
        6: d = -1;
        default: d = $urandom_range(0, 4);
      endcase
      access(r, 4'($urandom_range(0, 15)), a0, bn, 16'($urandom), 16'($urandom),
             d, $urandom_range(1, 4), st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
